// File: rtl/pc_redirect_unit.sv
// Fetch PC register with stall-parked redirects.
// Reports redirect pulses, misaligned targets and a saturating count.
module pc_redirect_unit #(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_le,
    input  logic [2:0]        decision_in,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] jal_target,
    input  logic [ADDR_W-1:0] jalr_target,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] npc_out,
    output logic              redirect_pending,
    output logic              redirect_taken,
    output logic              misalign_fault,
    output logic [CNT_W-1:0]  redirect_count
);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic              pend_mis_q, pend_mis_d;
    logic              taken_q, mis_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              load, load_mis;

    logic              is_br, is_jal, is_jalr, sel_valid;
    logic [ADDR_W-1:0] raw_tgt, sel_tgt;
    logic              sel_mis;

    assign is_br     = decision_in == 3'b001;
    assign is_jal    = decision_in == 3'b010;
    assign is_jalr   = decision_in == 3'b011;
    assign sel_valid = is_br | is_jal | is_jalr;

    always_comb begin
        raw_tgt = '0;
        unique case (1'b1)
            is_br:   raw_tgt = branch_target;
            is_jal:  raw_tgt = jal_target;
            is_jalr: raw_tgt = {jalr_target[ADDR_W-1:1], 1'b0};
            default: raw_tgt = '0;
        endcase
    end

    // bit 1 flags misalignment; low bits are always dropped before use
    assign sel_mis = sel_valid & raw_tgt[1];
    assign sel_tgt = {raw_tgt[ADDR_W-1:2], 2'b00};
    assign npc_out = pc_q + ADDR_W'(4);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        pend_mis_d = pend_mis_q;
        load       = 1'b0;
        load_mis   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pc_le) begin
                    if (sel_valid) begin
                        pc_d     = sel_tgt;
                        load     = 1'b1;
                        load_mis = sel_mis;
                    end else begin
                        pc_d = npc_out;
                    end
                end else if (sel_valid) begin
                    pend_tgt_d = sel_tgt;
                    pend_mis_d = sel_mis;
                    state_d    = PENDING;
                end
            end
            PENDING: begin
                if (pc_le) begin
                    load    = 1'b1;
                    state_d = IDLE;
                    if (sel_valid) begin
                        pc_d     = sel_tgt;
                        load_mis = sel_mis;
                    end else begin
                        pc_d     = pend_tgt_q;
                        load_mis = pend_mis_q;
                    end
                end else if (sel_valid) begin
                    pend_tgt_d = sel_tgt;
                    pend_mis_d = sel_mis;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            pend_tgt_q <= '0;
            pend_mis_q <= 1'b0;
            taken_q    <= 1'b0;
            mis_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            pend_mis_q <= pend_mis_d;
            taken_q    <= load;
            mis_q      <= load_mis;
            if (load && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign pc_out           = pc_q;
    assign redirect_pending = state_q == PENDING;
    assign redirect_taken   = taken_q;
    assign misalign_fault   = mis_q;
    assign redirect_count   = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit.
// Drives vectors 1ns after each rising edge and checks registered outputs.
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_le;
    logic [2:0]  decision_in;
    logic [31:0] branch_target, jal_target, jalr_target;
    logic [31:0] pc_out, npc_out;
    logic        redirect_pending, redirect_taken, misalign_fault;
    logic [15:0] redirect_count;

    int checks   = 0;
    int failures = 0;

    pc_redirect_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pc_le            (pc_le),
        .decision_in      (decision_in),
        .branch_target    (branch_target),
        .jal_target       (jal_target),
        .jalr_target      (jalr_target),
        .pc_out           (pc_out),
        .npc_out          (npc_out),
        .redirect_pending (redirect_pending),
        .redirect_taken   (redirect_taken),
        .misalign_fault   (misalign_fault),
        .redirect_count   (redirect_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string tag, input logic [31:0] pc,
                          input logic pend, input logic tk,
                          input logic mis, input logic [15:0] cnt);
        chk({tag, ".pc"}, pc_out, pc);
        chk({tag, ".pend"}, 32'(redirect_pending), 32'(pend));
        chk({tag, ".taken"}, 32'(redirect_taken), 32'(tk));
        chk({tag, ".mis"}, 32'(misalign_fault), 32'(mis));
        chk({tag, ".cnt"}, 32'(redirect_count), 32'(cnt));
    endtask

    initial begin
        rst_n         = 1'b0;
        pc_le         = 1'b0;
        decision_in   = 3'b000;
        branch_target = '0;
        jal_target    = '0;
        jalr_target   = '0;
        #12;
        chk_st("reset", 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
        rst_n = 1'b1;

        // sequential fetch
        pc_le = 1'b1;
        chk("npc0", npc_out, 32'h4);
        step(); chk_st("seq1", 32'h4, 0, 0, 0, 16'd0);
        step(); chk_st("seq2", 32'h8, 0, 0, 0, 16'd0);
        step(); chk_st("seq3", 32'hC, 0, 0, 0, 16'd0);
        step(); chk("seq4.pc", pc_out, 32'h10);

        // live branch
        decision_in   = 3'b001;
        branch_target = 32'h100;
        step(); chk_st("br", 32'h100, 0, 1, 0, 16'd1);
        decision_in = 3'b000;
        step(); chk_st("br_after", 32'h104, 0, 0, 0, 16'd1);

        // JAL parked under stall
        pc_le       = 1'b0;
        decision_in = 3'b010;
        jal_target  = 32'h200;
        step(); chk_st("park_jal", 32'h104, 1, 0, 0, 16'd1);
        decision_in = 3'b000;
        step(); chk_st("stall1", 32'h104, 1, 0, 0, 16'd1);
        step(); chk_st("stall2", 32'h104, 1, 0, 0, 16'd1);
        pc_le = 1'b1;
        step(); chk_st("apply_jal", 32'h200, 0, 1, 0, 16'd2);
        step(); chk_st("jal_after", 32'h204, 0, 0, 0, 16'd2);

        // JALR alignment
        decision_in = 3'b011;
        jalr_target = 32'h303;
        step(); chk_st("jalr303", 32'h300, 0, 1, 1, 16'd3);
        decision_in = 3'b000;
        step(); chk_st("jalr_after", 32'h304, 0, 0, 0, 16'd3);
        decision_in = 3'b011;
        jalr_target = 32'h301;
        step(); chk_st("jalr301", 32'h300, 0, 1, 0, 16'd4);

        // overwrite then live beats parked
        pc_le         = 1'b0;
        decision_in   = 3'b001;
        branch_target = 32'h400;
        step(); chk_st("park400", 32'h300, 1, 0, 0, 16'd4);
        decision_in = 3'b010;
        jal_target  = 32'h500;
        step(); chk_st("park500", 32'h300, 1, 0, 0, 16'd4);
        pc_le         = 1'b1;
        decision_in   = 3'b001;
        branch_target = 32'h600;
        step(); chk_st("live600", 32'h600, 0, 1, 0, 16'd5);

        // youngest parked target wins when applied
        pc_le         = 1'b0;
        branch_target = 32'h400;
        step();
        decision_in = 3'b010;
        jal_target  = 32'h500;
        step();
        pc_le       = 1'b1;
        decision_in = 3'b000;
        step(); chk_st("young500", 32'h500, 0, 1, 0, 16'd6);

        // reserved code acts as sequential
        decision_in = 3'b101;
        step(); chk_st("rsvd", 32'h504, 0, 0, 0, 16'd6);

        // misaligned parked target faults only when loaded
        pc_le         = 1'b0;
        decision_in   = 3'b001;
        branch_target = 32'h702;
        step(); chk_st("park702", 32'h504, 1, 0, 0, 16'd6);
        pc_le       = 1'b1;
        decision_in = 3'b000;
        step(); chk_st("apply702", 32'h700, 0, 1, 1, 16'd7);

        // PC+4 wrap
        decision_in = 3'b010;
        jal_target  = 32'hFFFF_FFFC;
        step(); chk_st("top", 32'hFFFF_FFFC, 0, 1, 0, 16'd8);
        decision_in = 3'b000;
        chk("npc_wrap", npc_out, 32'h0);
        step(); chk_st("wrap", 32'h0, 0, 0, 0, 16'd8);

        // counter saturation
        decision_in   = 3'b001;
        branch_target = 32'h800;
        repeat (65527) @(posedge clk);
        #1;
        chk("cnt_full", 32'(redirect_count), 32'h0000_FFFF);
        step(); chk_st("cnt_sat", 32'h800, 0, 1, 0, 16'hFFFF);

        // reset during PENDING
        pc_le       = 1'b0;
        decision_in = 3'b010;
        jal_target  = 32'h900;
        step(); chk("rst_pend.pre", 32'(redirect_pending), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_st("rst_pend", 32'h0, 0, 0, 0, 16'd0);
        decision_in = 3'b000;
        pc_le       = 1'b1;
        #2;
        rst_n = 1'b1;
        step(); chk_st("post_rst", 32'h4, 0, 0, 0, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
